// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx write-side arbiter and the uart_tx configuration.
package uart_pkg;

  // Width of a requester index; covers up to 8 requesters.
  localparam int unsigned GRANT_W = 3;

  // Width of the per-grant byte and idle counters.
  localparam int unsigned CNT_W = 8;

  // Arbiter FSM encoding, kept bit-compatible with the legacy register map.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the FIFO write port, as seen by the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               fifowrfull;
  logic               fifowrreq;
  logic [7:0]         fifowrdata;

  // Requesters and FIFO side: drive streams and full flag, observe accepts and writes.
  modport master (
    output req_valid,
    output req_data,
    output req_last,
    output fifowrfull,
    input  req_ready,
    input  fifowrreq,
    input  fifowrdata
  );

  // Arbiter side.
  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  fifowrfull,
    output req_ready,
    output fifowrreq,
    output fifowrdata
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo N_REQ.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [GRANT_W-1:0] ptr,
  output logic               hit,
  output logic [GRANT_W-1:0] idx
);

  logic [N_REQ-1:0] rot;
  int unsigned      off;
  int unsigned      sum;

  // Rotate so that bit 0 is the requester at ptr.
  always_comb begin
    rot = N_REQ'({req, req} >> ptr);
  end

  // Lowest set bit of the rotated vector, then map back to an absolute index.
  always_comb begin
    hit = 1'b0;
    off = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!hit && rot[k]) begin
        hit = 1'b1;
        off = k;
      end
    end
    sum = int'(ptr) + off;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end
    idx = GRANT_W'(sum);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing the uart_tx FIFO write port
// between N_REQ byte-stream requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MAX_PKT = 64,
  parameter int unsigned IDLE_TO = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arb_en,
  uart_tx_arbiter_if.slave   bus,
  output logic               grant_vld,
  output logic [GRANT_W-1:0] grant_id,
  output logic               err_timeout
);

  logic [0:0]         state;
  logic [GRANT_W-1:0] rr_ptr;
  logic [CNT_W-1:0]   byte_cnt;
  logic [CNT_W-1:0]   idle_cnt;

  logic               pick_hit;
  logic [GRANT_W-1:0] pick_idx;

  logic               g_valid;
  logic               g_last;
  logic [7:0]         g_data;
  logic               handshake;
  logic               rel_pkt;
  logic               rel_to;
  logic [GRANT_W-1:0] ptr_next;

  uart_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  // Select the granted requester's stream signals.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_id == GRANT_W'(i)) begin
        g_valid = bus.req_valid[i];
        g_last  = bus.req_last[i];
        g_data  = bus.req_data[8*i +: 8];
      end
    end
  end

  // Handshake and release decisions for the current XFER cycle.
  always_comb begin
    handshake   = (state == XFER) && g_valid && !bus.fifowrfull;
    rel_pkt     = handshake && (g_last || (byte_cnt == CNT_W'(MAX_PKT - 1)));
    // A timeout needs valid low, so it can never coincide with a handshake release.
    rel_to      = (state == XFER) && !g_valid && (idle_cnt == CNT_W'(IDLE_TO - 1));
    err_timeout = rel_to;
    ptr_next    = (grant_id == GRANT_W'(N_REQ - 1)) ? '0 : grant_id + GRANT_W'(1);
  end

  // Route the granted stream to the FIFO; everything idles low outside XFER.
  always_comb begin
    bus.req_ready  = '0;
    bus.fifowrreq  = 1'b0;
    bus.fifowrdata = '0;
    if (state == XFER) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (grant_id == GRANT_W'(i)) begin
          bus.req_ready[i] = !bus.fifowrfull;
        end
      end
      bus.fifowrreq  = g_valid && !bus.fifowrfull;
      bus.fifowrdata = g_data;
    end
  end

  // Grant FSM, round-robin pointer and per-grant byte/idle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      byte_cnt  <= '0;
      idle_cnt  <= '0;
      grant_vld <= 1'b0;
      grant_id  <= '0;
    end else if (state == IDLE) begin
      if (arb_en && pick_hit) begin
        state     <= XFER;
        grant_vld <= 1'b1;
        grant_id  <= pick_idx;
        byte_cnt  <= '0;
        idle_cnt  <= '0;
      end
    end else begin
      if (handshake) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
        idle_cnt <= '0;
      end else if (!g_valid) begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end
      if (rel_pkt || rel_to) begin
        state     <= IDLE;
        grant_vld <= 1'b0;
        rr_ptr    <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a packet-level model predicts the
// FIFO write stream and timeout events; a monitor checks what the DUT emits.
module tb_uart_tx_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned MAXP = 4;
  localparam int unsigned ITO  = 8;

  typedef struct {
    bit         is_to;
    logic [2:0] id;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arb_en = 1'b0;
  logic       grant_vld;
  logic [2:0] grant_id;
  logic       err_timeout;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(
    .N_REQ   (N),
    .MAX_PKT (MAXP),
    .IDLE_TO (ITO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arb_en      (arb_en),
    .bus         (bus),
    .grant_vld   (grant_vld),
    .grant_id    (grant_id),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t         exp_q[$];
  logic [8:0]  drv_q[N][$];
  logic [8:0]  stg_q[N][$];
  int          tests = 0;
  int          fails = 0;
  int unsigned wr_seen = 0;
  int unsigned last_hs = 0;
  int unsigned mptr = 0;
  int unsigned full_hold = 0;
  bit          rand_full = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit drv_busy();
    for (int r = 0; r < N; r++) if (drv_q[r].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Hand staged packets to the drivers and predict the write/timeout sequence:
  // round-robin over requesters with data, each grant running to its last byte,
  // MAXP bytes, or an idle timeout when the requester runs dry mid-packet.
  task automatic issue();
    logic [8:0]  b;
    int unsigned r;
    int unsigned cnt;
    ev_t         e;
    bit          any;
    for (int i = 0; i < N; i++)
      foreach (stg_q[i][k]) drv_q[i].push_back(stg_q[i][k]);
    forever begin
      any = 1'b0;
      r = 0;
      for (int unsigned k = 0; k < N; k++) begin
        if (!any && stg_q[(mptr + k) % N].size() > 0) begin
          any = 1'b1;
          r = (mptr + k) % N;
        end
      end
      if (!any) break;
      cnt = 0;
      forever begin
        b = stg_q[r].pop_front();
        e.is_to = 1'b0; e.id = 3'(r); e.data = b[7:0];
        exp_q.push_back(e);
        cnt++;
        if (b[8] || cnt == MAXP) break;
        if (stg_q[r].size() == 0) begin
          e.is_to = 1'b1; e.data = '0;
          exp_q.push_back(e);
          break;
        end
      end
      mptr = (r + 1) % N;
    end
  endtask

  task automatic stage(input int r, input int len, input bit with_last);
    for (int i = 0; i < len; i++)
      stg_q[r].push_back({(with_last && i == len - 1), 8'($urandom_range(0, 255))});
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || drv_busy() || grant_vld) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_left"}, exp_q.size(), 0);
  endtask

  task automatic wait_writes(input int unsigned target, input int budget);
    int n = 0;
    while (wr_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_writes", 32'(wr_seen >= target), 1);
  endtask

  // Requester drivers and FIFO full model: pop a byte after each accepted handshake.
  initial begin : driver
    logic [N-1:0] hs;
    bus.req_valid  = '0;
    bus.req_last   = '0;
    bus.req_data   = '0;
    bus.fifowrfull = 1'b0;
    forever begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int r = 0; r < N; r++) begin
        if (hs[r] && drv_q[r].size() > 0) void'(drv_q[r].pop_front());
        if (drv_q[r].size() > 0) begin
          bus.req_valid[r]       = 1'b1;
          bus.req_last[r]        = drv_q[r][0][8];
          bus.req_data[8*r +: 8] = drv_q[r][0][7:0];
        end else begin
          bus.req_valid[r]       = 1'b0;
          bus.req_last[r]        = 1'b0;
          bus.req_data[8*r +: 8] = '0;
        end
      end
      if (full_hold > 0) begin
        bus.fifowrfull = 1'b1;
        full_hold--;
      end else if (rand_full) begin
        bus.fifowrfull = ($urandom_range(0, 3) == 0);
      end else begin
        bus.fifowrfull = 1'b0;
      end
    end
  end

  // Monitor: compare every FIFO write and timeout pulse against the scoreboard.
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.fifowrfull)
          check("full_blocks", 32'({bus.fifowrreq, bus.req_ready}), 0);
        if (bus.fifowrreq) begin
          wr_seen++;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_write: got id %0d data 0x%0h, expected nothing", grant_id, bus.fifowrdata);
          end else begin
            e = exp_q.pop_front();
            if (e.is_to) begin
              tests++; fails++;
              $display("FAIL write_order: got write id %0d, expected timeout id %0d", grant_id, e.id);
            end else begin
              check("write_id_data", 32'({grant_vld, grant_id, bus.fifowrdata}), 32'({1'b1, e.id, e.data}));
              check("ready_onehot", 32'(bus.req_ready), 32'(1) << e.id);
            end
          end
          last_hs = cyc;
        end
        if (err_timeout) begin
          if (exp_q.size() == 0 || !exp_q[0].is_to) begin
            tests++; fails++;
            $display("FAIL unexpected_timeout: got err_timeout id %0d, expected none", grant_id);
          end else begin
            e = exp_q.pop_front();
            check("timeout_id", 32'({grant_vld, grant_id}), 32'({1'b1, e.id}));
            check("timeout_delay", cyc - last_hs, ITO);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    repeat (3) @(posedge clk);
    #2;
    check("reset_outs", 32'({bus.req_ready, bus.fifowrreq, bus.fifowrdata, grant_vld, grant_id, err_timeout}), 0);
    rst_n  = 1'b1;
    arb_en = 1'b1;
    @(negedge clk);

    // Contention, rr_ptr=0: req0 packet whole, then req2.
    stage(0, 2, 1'b1);
    stage(2, 2, 1'b1);
    issue();
    wait_done("contention", 200);

    // Single requester, fixed bytes, grant one cycle after valid.
    stg_q[1].push_back(9'h041);
    stg_q[1].push_back(9'h042);
    stg_q[1].push_back(9'h143);
    issue();
    @(posedge clk);
    #2;
    @(negedge clk);
    check("arb_cycle", 32'({grant_vld, bus.fifowrreq}), 0);
    @(negedge clk);
    check("grant_latency", 32'({grant_vld, grant_id}), 32'({1'b1, 3'd1}));
    wait_done("single", 200);

    // MAX_PKT split: req3 streams 6 bytes, req1 waits between the two halves.
    stage(3, 6, 1'b1);
    stage(1, 2, 1'b1);
    issue();
    wait_done("maxpkt", 300);

    // Backpressure mid-packet for 5 cycles.
    stage(2, 3, 1'b1);
    issue();
    wait_writes(wr_seen + 1, 100);
    full_hold = 5;
    wait_done("backpressure", 300);

    // Idle timeout after one byte without last, then req1 served.
    stage(0, 1, 1'b0);
    stage(1, 2, 1'b1);
    issue();
    wait_done("timeout", 300);

    // Randomized traffic with random FIFO full.
    rand_full = 1'b1;
    for (int round = 0; round < 12; round++) begin
      for (int r = 0; r < N; r++)
        for (int p = 0; p < int'($urandom_range(0, 2)); p++)
          stage(r, int'($urandom_range(1, 7)), 1'b1);
      issue();
      wait_done("random", 3000);
    end
    rand_full = 1'b0;

    // Reset mid-packet, then arb_en gating.
    stage(2, 6, 1'b1);
    issue();
    wait_writes(wr_seen + 2, 100);
    @(posedge clk);
    #3;
    rst_n  = 1'b0;
    #1;
    check("reset_mid", 32'({bus.req_ready, bus.fifowrreq, bus.fifowrdata, grant_vld, grant_id, err_timeout}), 0);
    for (int r = 0; r < N; r++) drv_q[r].delete();
    exp_q.delete();
    mptr   = 0;
    arb_en = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    stage(0, 1, 1'b1);
    stage(1, 1, 1'b1);
    issue();
    repeat (4) begin
      @(negedge clk);
      check("arb_en_off", 32'({grant_vld, bus.fifowrreq}), 0);
    end
    @(posedge clk);
    #2;
    arb_en = 1'b1;
    @(negedge clk);
    check("arb_en_cycle", 32'(grant_vld), 0);
    @(negedge clk);
    check("arb_en_grant", 32'({grant_vld, grant_id}), 32'({1'b1, 3'd0}));
    wait_done("arb_en", 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
